time_report_tx: RTL and testbench

Serialises the current time value into an ASCII report line, `HH:MM:SS.CC` followed by CR LF, and feeds it byte by byte to the UART transmitter. It is the outbound end of the UART command path: the command decoder drives control bits into the watch/stopwatch top, and this block sends that top's `time_data` back to the host. A request pulse comes from the command decoder (report command) or a button, and the block handshakes with `uart_tx` over a start/done pair.

---
 rtl/time_report_pkg.sv | 35 +++
 rtl/time_report_tx_bin2bcd_2digit.sv | 17 +
 rtl/time_report_tx.sv | 110 +++++++++++
 tb/tb_time_report_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/time_report_pkg.sv
// Shared definitions for the time report transmitter.
//   - FSM state encoding
//   - ASCII constants used in the report line
//   - bit positions of each field within the 24-bit time word
package time_report_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // time_data = {hour[23:19], min[18:13], sec[12:7], msec[6:0]}
  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 19;
  localparam int MIN_MSB  = 18;
  localparam int MIN_LSB  = 13;
  localparam int SEC_MSB  = 12;
  localparam int SEC_LSB  = 7;
  localparam int MSEC_MSB = 6;
  localparam int MSEC_LSB = 0;

  localparam int NUM_FIELDS = 4;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/time_report_tx_bin2bcd_2digit.sv
// Two-digit binary to BCD converter (combinational).
//   bin  : 7-bit unsigned value
//   tens : bin clamped to 99, divided by 10
//   ones : bin clamped to 99, modulo 10
module bin2bcd_2digit (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] v;

  assign v    = (bin > 7'd99) ? 7'd99 : bin;
  assign tens = 4'(v / 7'd10);
  assign ones = 4'(v % 7'd10);

endmodule

// File: rtl/time_report_tx.sv
// Serialises a snapshot of time_data as "HH:MM:SS.CC" (+ CR LF when
// NEWLINE=1) and hands it to a UART transmitter one byte at a time.
//   clk, rst   : clock, asynchronous active-low reset
//   time_data  : {hour, min, sec, centisec} to report
//   i_req      : report request pulse, accepted only when idle
//   tx_done    : uart_tx finished the current byte
//   tx_start   : one-cycle pulse, uart_tx latches tx_data
//   tx_data    : current byte, held until the matching tx_done
//   o_busy     : message in progress
//   o_done     : one-cycle pulse after the final byte completes
module time_report_tx
  import time_report_pkg::*;
#(
  parameter bit NEWLINE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_data,
  input  logic        i_req,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [3:0] LAST = NEWLINE ? 4'd12 : 4'd10;

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [23:0] snap;
  logic [7:0]  byte_sel;

  logic [NUM_FIELDS-1:0][6:0] fld;
  logic [NUM_FIELDS-1:0][3:0] tens;
  logic [NUM_FIELDS-1:0][3:0] ones;

  // Conversion works from the snapshot only, so later time_data changes
  // cannot leak into a message already in flight.
  assign fld[0] = 7'(snap[HOUR_MSB:HOUR_LSB]);
  assign fld[1] = 7'(snap[MIN_MSB:MIN_LSB]);
  assign fld[2] = 7'(snap[SEC_MSB:SEC_LSB]);
  assign fld[3] = 7'(snap[MSEC_MSB:MSEC_LSB]);

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_cvt
    bin2bcd_2digit u_cvt (
      .bin  (fld[f]),
      .tens (tens[f]),
      .ones (ones[f])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_req)   state_nxt = ST_SEND;
      ST_SEND:              state_nxt = ST_WAIT;
      ST_WAIT: if (tx_done) state_nxt = (idx == LAST) ? ST_IDLE : ST_SEND;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= 4'd0;
      snap   <= 24'd0;
      o_done <= 1'b0;
    end else begin
      o_done <= (state == ST_WAIT) && tx_done && (idx == LAST);
      if (state == ST_IDLE && i_req) begin
        snap <= time_data;
        idx  <= 4'd0;
      end else if (state == ST_WAIT && tx_done && idx != LAST) begin
        idx  <= idx + 4'd1;
      end
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      4'd0:  byte_sel = digit_ascii(tens[0]);
      4'd1:  byte_sel = digit_ascii(ones[0]);
      4'd2:  byte_sel = ASCII_COLON;
      4'd3:  byte_sel = digit_ascii(tens[1]);
      4'd4:  byte_sel = digit_ascii(ones[1]);
      4'd5:  byte_sel = ASCII_COLON;
      4'd6:  byte_sel = digit_ascii(tens[2]);
      4'd7:  byte_sel = digit_ascii(ones[2]);
      4'd8:  byte_sel = ASCII_DOT;
      4'd9:  byte_sel = digit_ascii(tens[3]);
      4'd10: byte_sel = digit_ascii(ones[3]);
      4'd11: byte_sel = NEWLINE ? ASCII_CR : 8'h00;
      4'd12: byte_sel = NEWLINE ? ASCII_LF : 8'h00;
      default: byte_sel = 8'h00;
    endcase
  end

  // Outputs depend only on registers; tx_data is forced to zero while idle
  // so the line is quiet (and 0x00 out of reset).
  assign tx_start = (state == ST_SEND);
  assign o_busy   = (state != ST_IDLE);
  assign tx_data  = o_busy ? byte_sel : 8'h00;

endmodule

// File: tb/tb_time_report_tx.sv
module tb_time_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] time_data;
  logic        req1, done1, req0, done0;
  logic        start1, busy1, odone1, start0, busy0, odone0;
  logic [7:0]  data1, data0;

  int total  = 0;
  int passed = 0;
  int nst1   = 0;
  int nst0   = 0;

  always #5 clk = ~clk;

  time_report_tx #(.NEWLINE(1'b1)) dut_nl (
    .clk(clk), .rst(rst), .time_data(time_data), .i_req(req1), .tx_done(done1),
    .tx_start(start1), .tx_data(data1), .o_busy(busy1), .o_done(odone1)
  );

  time_report_tx #(.NEWLINE(1'b0)) dut_nonl (
    .clk(clk), .rst(rst), .time_data(time_data), .i_req(req0), .tx_done(done0),
    .tx_start(start0), .tx_data(data0), .o_busy(busy0), .o_done(odone0)
  );

  always @(posedge clk) begin
    if (start1) nst1 <= nst1 + 1;
    if (start0) nst0 <= nst0 + 1;
  end

  // Reference: the report line as text, from field values with plain arithmetic.
  function automatic logic [7:0] exp_byte(input logic [23:0] td, input int k);
    int f[4];
    int v;
    logic [7:0] s[13];
    f[0] = int'(td[23:19]);
    f[1] = int'(td[18:13]);
    f[2] = int'(td[12:7]);
    f[3] = int'(td[6:0]);
    for (int i = 0; i < 4; i++) begin
      v = (f[i] > 99) ? 99 : f[i];
      s[3*i]   = 8'(48 + v / 10);
      s[3*i+1] = 8'(48 + v % 10);
    end
    s[2] = ":"; s[5] = ":"; s[8] = "."; s[11] = 8'h0D; s[12] = 8'h0A;
    return s[k];
  endfunction

  function automatic logic [23:0] mk_time(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic o_start(input bit sel); return sel ? start0 : start1; endfunction
  function automatic logic [7:0] o_data(input bit sel); return sel ? data0 : data1; endfunction
  function automatic logic o_busy(input bit sel); return sel ? busy0 : busy1; endfunction
  function automatic logic o_dn(input bit sel); return sel ? odone0 : odone1; endfunction
  function automatic int o_cnt(input bit sel); return sel ? nst0 : nst1; endfunction

  task automatic set_req(input bit sel, input logic v);
    if (sel) req0 = v; else req1 = v;
  endtask

  task automatic set_done(input bit sel, input logic v);
    if (sel) done0 = v; else done1 = v;
  endtask

  task automatic req_pulse(input bit sel);
    set_req(sel, 1'b1);
    step;
    set_req(sel, 1'b0);
  endtask

  // Plays the uart_tx side for one message; stops after n_take bytes
  // (without answering the last one) when n_take is short of the full line.
  task automatic run_msg(input bit sel, input logic [23:0] td_exp, input int n_take,
                         input logic [23:0] td_change, input int change_after,
                         input bit req_mode, input int delay);
    int n = sel ? 11 : 13;
    int s0 = o_cnt(sel);
    int t;
    bit stable;
    logic [7:0] b;
    for (int k = 0; k < n_take; k++) begin
      t = 0;
      while (!o_start(sel) && t < 60) begin step; t++; end
      chk($sformatf("start_seen%0d", k), {31'd0, o_start(sel)}, 32'd1);
      if (!o_start(sel)) return;
      chk($sformatf("byte%0d", k), {24'd0, o_data(sel)}, {24'd0, exp_byte(td_exp, k)});
      chk($sformatf("busy%0d", k), {31'd0, o_busy(sel)}, 32'd1);
      b = o_data(sel);
      stable = 1'b1;
      for (int d = 0; d < delay; d++) begin
        step;
        set_req(sel, req_mode && d == 1);
        if (o_data(sel) !== b || o_start(sel) !== 1'b0) stable = 1'b0;
      end
      set_req(sel, 1'b0);
      chk($sformatf("hold%0d", k), {31'd0, stable}, 32'd1);
      if (k == change_after - 1) time_data = td_change;
      if (k == n_take - 1 && n_take < n) return;
      set_done(sel, 1'b1);
      if (req_mode && k == n - 1) set_req(sel, 1'b1);
      step;
      set_done(sel, 1'b0);
      set_req(sel, 1'b0);
    end
    chk("busy_fall", {31'd0, o_busy(sel)}, 32'd0);
    chk("done_pulse", {31'd0, o_dn(sel)}, 32'd1);
    chk("no_restart", {31'd0, o_start(sel)}, 32'd0);
    chk("start_count", 32'(o_cnt(sel) - s0), 32'(n));
  endtask

  initial begin
    logic [23:0] td, td2;
    int dly;
    rst = 1'b0; time_data = '0; req1 = 0; done1 = 0; req0 = 0; done0 = 0;
    repeat (3) step;
    chk("rst_start", {31'd0, start1}, 32'd0);
    chk("rst_data",  {24'd0, data1},  32'd0);
    chk("rst_busy",  {31'd0, busy1},  32'd0);
    chk("rst_done",  {31'd0, odone1}, 32'd0);
    rst = 1'b1;
    repeat (3) step;
    chk("idle_data", {24'd0, data1}, 32'd0);
    chk("idle_busy", {31'd0, busy1}, 32'd0);

    // Basic message, 13:45:07.89
    td = mk_time(13, 45, 7, 89);
    time_data = td;
    req_pulse(0);
    chk("req_latency", {31'd0, start1}, 32'd1);
    run_msg(0, td, 13, 24'd0, 0, 0, 20);
    step;
    chk("done_single", {31'd0, odone1}, 32'd0);

    // Snapshot: time_data cleared after byte 3
    repeat (4) step;
    req_pulse(0);
    run_msg(0, td, 13, 24'd0, 3, 0, 20);
    step;

    // Requests while busy (incl. with last tx_done), then one right after busy falls
    time_data = td;
    req_pulse(0);
    run_msg(0, td, 13, 24'd0, 0, 1, 20);
    td2 = mk_time(23, 59, 59, 127);
    time_data = td2;
    req_pulse(0);
    chk("req_after_fall", {31'd0, start1}, 32'd1);
    run_msg(0, td2, 13, 24'd0, 0, 0, 20);
    step;

    // Randomised values, including out-of-range fields, random response delays
    for (int r = 0; r < 4; r++) begin
      td2 = mk_time($urandom_range(0, 31), $urandom_range(0, 63),
                    $urandom_range(0, 63), $urandom_range(0, 127));
      dly = $urandom_range(1, 25);
      time_data = td2;
      req_pulse(0);
      time_data = 24'($urandom);
      run_msg(0, td2, 13, 24'd0, 0, 0, dly);
      repeat ($urandom_range(1, 4)) step;
    end

    // Reset in the middle of byte 6, then a fresh message
    time_data = td;
    req_pulse(0);
    run_msg(0, td, 6, 24'd0, 0, 0, 10);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_start", {31'd0, start1}, 32'd0);
    chk("mid_rst_data",  {24'd0, data1},  32'd0);
    chk("mid_rst_busy",  {31'd0, busy1},  32'd0);
    chk("mid_rst_done",  {31'd0, odone1}, 32'd0);
    step;
    rst = 1'b1;
    step;
    td2 = mk_time(2, 3, 4, 5);
    time_data = td2;
    req_pulse(0);
    run_msg(0, td2, 13, 24'd0, 0, 0, 15);
    step;

    // No line ending variant
    time_data = td;
    req_pulse(1);
    chk("nonl_latency", {31'd0, start0}, 32'd1);
    run_msg(1, td, 11, 24'd0, 0, 0, 20);
    step;
    chk("nonl_done_single", {31'd0, odone0}, 32'd0);
    chk("nl_idle", {31'd0, busy1}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
